// File: rtl/jtcps1_fbwr.sv
// Frame-buffer writer: captures mixed RGB pixels into a double-buffered line RAM
// and streams each completed line out through a line_wr/line_wr_ok handshake.
module jtcps1_fbwr #(
  parameter int HACTIVE = 384,
  parameter int AW      = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          LHBL_dly,
  input  logic          LVBL_dly,
  input  logic [7:0]    red,
  input  logic [7:0]    green,
  input  logic [7:0]    blue,
  output logic [11:0]   line_data,
  output logic [AW-1:0] line_addr,
  output logic [7:0]    line_row,
  output logic          line_wr,
  input  logic          line_wr_ok,
  output logic          overrun
);

  localparam logic [AW:0] LP_HMAX = HACTIVE[AW:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PRESENT
  } state_t;

  state_t        r_state;
  state_t        w_next;

  // Both banks live in one array; the bank select is the top address bit.
  logic [11:0]   r_mem [2**(AW+1)];

  logic          r_lhbl_q;
  logic          r_wr_bank;
  logic          r_start;
  logic          r_overrun;
  logic [AW:0]   r_col;
  logic [AW:0]   r_len;
  logic [7:0]    r_row;
  logic [7:0]    r_rd_row;
  logic [AW-1:0] r_rd_col;
  logic [11:0]   r_rd_q;

  logic          w_eol;
  logic          w_line_done;
  logic          w_cap;
  logic          w_busy;
  logic          w_accept;
  logic          w_last;
  logic          w_unused;

  assign w_eol       = r_lhbl_q & ~LHBL_dly;
  assign w_line_done = w_eol & (r_col != '0);
  assign w_cap       = pxl_cen & LHBL_dly & LVBL_dly & (r_col < LP_HMAX);
  // A pending start counts as busy, so back-to-back line ends cannot retoggle the bank.
  assign w_busy      = (r_state != S_IDLE) | r_start;
  assign w_accept    = (r_state == S_PRESENT) & line_wr_ok;
  assign w_last      = ({1'b0, r_rd_col} == (r_len - 1'b1));
  assign w_unused    = ^{red[3:0], green[3:0], blue[3:0]};

  // Capture side
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lhbl_q  <= 1'b0;
      r_wr_bank <= 1'b0;
      r_start   <= 1'b0;
      r_overrun <= 1'b0;
      r_col     <= '0;
      r_len     <= '0;
      r_row     <= '0;
      r_rd_row  <= '0;
    end else begin
      r_lhbl_q <= LHBL_dly;
      r_start  <= 1'b0;
      if (w_line_done) begin
        r_col <= '0;
        if (!w_busy) begin
          r_wr_bank <= ~r_wr_bank;
          r_len     <= r_col;
          r_rd_row  <= r_row;
          r_start   <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_cap) begin
        r_col <= r_col + 1'b1;
      end
      if (!LVBL_dly)        r_row <= '0;
      else if (w_line_done) r_row <= r_row + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_cap) r_mem[{r_wr_bank, r_col[AW-1:0]}] <= {red[7:4], green[7:4], blue[7:4]};
  end

  always_ff @(posedge clk) begin
    if (rst)                       r_rd_q <= '0;
    else if (r_state == S_FETCH)   r_rd_q <= r_mem[{~r_wr_bank, r_rd_col}];
  end

  always_ff @(posedge clk) begin
    if (rst)                              r_rd_col <= '0;
    else if (r_state == S_IDLE && r_start) r_rd_col <= '0;
    else if (w_accept && !w_last)         r_rd_col <= r_rd_col + 1'b1;
  end

  // Reader FSM: state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Reader FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (r_start) w_next = S_FETCH;
      S_FETCH:   w_next = S_PRESENT;
      S_PRESENT: if (line_wr_ok) w_next = w_last ? S_IDLE : S_FETCH;
      default:   w_next = S_IDLE;
    endcase
  end

  // Reader FSM: outputs
  always_comb begin
    line_wr   = (r_state == S_PRESENT);
    line_data = r_rd_q;
    line_addr = r_rd_col;
    line_row  = r_rd_row;
    overrun   = r_overrun;
  end

endmodule

// File: tb/tb_jtcps1_fbwr.sv
// Directed bench for jtcps1_fbwr: line capture, transfer, backpressure,
// overrun, long/short lines, frame wrap and mid-transfer reset.
module tb_jtcps1_fbwr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pxl_cen = 1'b0;
  logic        LHBL_dly = 1'b0;
  logic        LVBL_dly = 1'b0;
  logic [7:0]  red = '0;
  logic [7:0]  green = '0;
  logic [7:0]  blue = '0;
  logic [11:0] line_data;
  logic [8:0]  line_addr;
  logic [7:0]  line_row;
  logic        line_wr;
  logic        line_wr_ok = 1'b1;
  logic        overrun;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int          ok_mode  = 0;   // 0: ok tied high, 1: every 4th cycle, 2: held low
  int unsigned cyc      = 0;

  typedef struct packed {
    logic [7:0]  row;
    logic [8:0]  addr;
    logic [11:0] data;
  } word_t;

  word_t q[$];

  jtcps1_fbwr #(.HACTIVE(384), .AW(9)) dut (
    .clk        (clk),
    .rst        (rst),
    .pxl_cen    (pxl_cen),
    .LHBL_dly   (LHBL_dly),
    .LVBL_dly   (LVBL_dly),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .line_data  (line_data),
    .line_addr  (line_addr),
    .line_row   (line_row),
    .line_wr    (line_wr),
    .line_wr_ok (line_wr_ok),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] pk(input int c);
    logic [7:0] r, g, b;
    r = c[7:0];
    g = r ^ 8'h5A;
    b = ~r;
    return {r[7:4], g[7:4], b[7:4]};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      case (ok_mode)
        0:       line_wr_ok = 1'b1;
        1:       line_wr_ok = (cyc % 4 == 0);
        default: line_wr_ok = 1'b0;
      endcase
    end
  end

  // Collect accepted words and check outputs hold while a word is pending
  initial begin
    logic        pend = 1'b0;
    logic [28:0] prev = '0;
    forever begin
      @(negedge clk);
      if (line_wr && pend)
        chk("stable", {3'b0, line_row, line_addr, line_data}, {3'b0, prev});
      if (line_wr && line_wr_ok) q.push_back({line_row, line_addr, line_data});
      pend = line_wr & ~line_wr_ok;
      prev = {line_row, line_addr, line_data};
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_line(input int npix, input int blank);
    if (npix == 0) begin
      LHBL_dly = 1'b1;
      pxl_cen  = 1'b0;
      step(4);
    end
    for (int i = 0; i < npix; i++) begin
      LHBL_dly = 1'b1;
      pxl_cen  = 1'b1;
      red      = i[7:0];
      green    = red ^ 8'h5A;
      blue     = ~red;
      step(1);
    end
    LHBL_dly = 1'b0;
    pxl_cen  = 1'b0;
    step(blank);
  endtask

  task automatic verify(input string tag, input int n, input int row);
    int unsigned e0;
    chk({tag, "_count"}, q.size(), n);
    e0 = n_errors;
    for (int i = 0; i < n && i < q.size() && n_errors == e0; i++) begin
      chk({tag, "_addr"}, {23'b0, q[i].addr}, i);
      chk({tag, "_data"}, {20'b0, q[i].data}, {20'b0, pk(i)});
      chk({tag, "_row"},  {24'b0, q[i].row}, row);
    end
    q.delete();
  endtask

  initial begin
    int unsigned guard;
    step(5);
    chk("rst_wr",   line_wr,   0);
    chk("rst_data", line_data, 0);
    chk("rst_addr", line_addr, 0);
    chk("rst_row",  line_row,  0);
    chk("rst_ovr",  overrun,   0);
    rst = 1'b0;
    step(3);
    LVBL_dly = 1'b1;
    step(3);

    for (int l = 0; l < 3; l++) begin
      send_line(384, 800);
      verify("basic", 384, l);
    end

    ok_mode = 1;
    send_line(384, 1700);
    verify("bp", 384, 3);
    ok_mode = 0;
    step(4);

    // Overrun: line 4 stalls in the reader, line 5 is dropped
    ok_mode = 2;
    step(2);
    send_line(384, 20);
    for (int i = 0; i < 384; i++) begin
      LHBL_dly = 1'b1;
      pxl_cen  = 1'b1;
      red      = 8'hFF - i[7:0];
      green    = red;
      blue     = red;
      step(1);
    end
    LHBL_dly = 1'b0;
    pxl_cen  = 1'b0;
    @(negedge clk);
    chk("ovr_early", overrun, 0);
    @(negedge clk);
    chk("ovr_set", overrun, 1);
    step(4);
    ok_mode = 0;
    step(900);
    verify("ovr_first", 384, 4);
    send_line(384, 800);
    verify("ovr_next", 384, 6);

    send_line(400, 800);
    verify("long", 384, 7);
    send_line(100, 300);
    verify("short", 100, 8);
    send_line(0, 20);
    verify("zero", 0, 0);
    send_line(50, 200);
    verify("after_zero", 50, 9);

    LVBL_dly = 1'b0;
    step(10);
    LVBL_dly = 1'b1;
    step(2);
    send_line(384, 800);
    verify("wrap0", 384, 0);
    send_line(10, 100);
    verify("wrap1", 10, 1);

    // Reset while word 50 of a line is being delivered
    chk("ovr_sticky", overrun, 1);
    send_line(384, 0);
    guard = 0;
    while (q.size() < 50 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("rst_reach50", q.size() >= 50, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_wr",   line_wr,   0);
    chk("mid_data", line_data, 0);
    chk("mid_addr", line_addr, 0);
    chk("mid_row",  line_row,  0);
    chk("mid_ovr",  overrun,   0);
    q.delete();
    step(20);
    chk("mid_tail", q.size(), 0);
    send_line(384, 800);
    verify("post_rst", 384, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
